// File: rtl/itr_sched.sv
// Interrupt scheduler: edge-latched pending bits, writable mask, fixed
// priority (index 0 highest), one itr pulse per service, GAP idle cycles
// after each return before the next fire.
// Optional: define ITR_TMO_EN to add a SERVICE timeout (TMOUT cycles)
// with a sticky err flag; without it SERVICE waits forever and err is 0.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | waiting: count down gap, then fire on any eligible source
// FIRE    | itr pulse cycle, itr_id names the chosen source
// SERVICE | waiting for itr_done (or timeout when ITR_TMO_EN)
module itr_sched #(
  parameter int NSRC  = 4,
  parameter int GAP   = 4,
  parameter int TMOUT = 255
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NSRC-1:0]         irq_in,
  input  logic                    mask_wr,
  input  logic [NSRC-1:0]         mask_data,
  input  logic                    itr_done,
  output logic                    itr,
  output logic [$clog2(NSRC)-1:0] itr_id,
  output logic                    busy,
  output logic [NSRC-1:0]         pend,
  output logic                    err
);
  localparam int IDW = $clog2(NSRC);
  // +2 keeps the width at least 1 even when GAP is 0
  localparam int GW  = $clog2(GAP + 2);

  typedef enum logic [1:0] {IDLE, FIRE, SERVICE} state_t;

  state_t          state, state_nxt;
  logic [NSRC-1:0] mask, irq_prev, eligible, rise, clr;
  logic [GW-1:0]   gap_cnt, gap_nxt;
  logic [IDW-1:0]  winner, id_nxt;
  logic            tmo_expired;

  assign rise     = irq_in & ~irq_prev;
  assign eligible = pend & mask;

  // lowest set index of eligible wins
  always_comb begin
    winner = '0;
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (eligible[i]) winner = IDW'(i);
    end
  end

  // next state, gap countdown, id latch and pend clear
  always_comb begin
    state_nxt = state;
    gap_nxt   = gap_cnt;
    id_nxt    = itr_id;
    clr       = '0;
    case (state)
      IDLE: begin
        if (gap_cnt != '0) begin
          gap_nxt = gap_cnt - 1'b1;
        end else if (eligible != '0) begin
          state_nxt   = FIRE;
          id_nxt      = winner;
          clr[winner] = 1'b1;
        end
      end
      FIRE: state_nxt = SERVICE;
      SERVICE: begin
        if (itr_done || tmo_expired) begin
          state_nxt = IDLE;
          gap_nxt   = GW'(GAP);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // state, registered outputs, pending/mask/edge-history registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= IDLE;
      itr      <= 1'b0;
      itr_id   <= '0;
      busy     <= 1'b0;
      pend     <= '0;
      mask     <= '1;
      irq_prev <= '0;
      gap_cnt  <= '0;
    end else begin
      state    <= state_nxt;
      itr      <= (state_nxt == FIRE);
      busy     <= (state_nxt != IDLE);
      itr_id   <= id_nxt;
      gap_cnt  <= gap_nxt;
      // a new edge on the bit being serviced wins over its clear
      pend     <= (pend & ~clr) | rise;
      irq_prev <= irq_in;
      if (mask_wr) mask <= mask_data;
    end
  end

`ifdef ITR_TMO_EN
  localparam int TW = $clog2(TMOUT + 1);
  logic [TW-1:0] tmo_cnt;

  // down-counter loaded in FIRE; terminal count in SERVICE means
  // TMOUT service cycles have elapsed
  assign tmo_expired = (state == SERVICE) && (tmo_cnt == '0);

  // timeout counter and sticky error; a same-cycle itr_done is a normal return
  always_ff @(posedge clk) begin
    if (!rst) begin
      tmo_cnt <= '0;
      err     <= 1'b0;
    end else begin
      if (state == FIRE) begin
        tmo_cnt <= TW'(TMOUT - 1);
      end else if (state == SERVICE && tmo_cnt != '0) begin
        tmo_cnt <= tmo_cnt - 1'b1;
      end
      if (tmo_expired && !itr_done) err <= 1'b1;
    end
  end
`else
  assign tmo_expired = 1'b0;
  assign err         = 1'b0;
`endif

endmodule

// File: tb/tb_itr_sched.sv
// Bench for itr_sched: directed scenarios then random traffic, every cycle
// compared against a behavioural model of the scheduler's rules.
module tb_itr_sched;
  localparam int NSRC  = 4;
  localparam int GAP   = 4;
  localparam int TMOUT = 8;
`ifdef ITR_TMO_EN
  localparam bit TMO_ON = 1'b1;
`else
  localparam bit TMO_ON = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic [NSRC-1:0] irq_in = '0;
  logic            mask_wr = 1'b0;
  logic [NSRC-1:0] mask_data = '0;
  logic            itr_done = 1'b0;
  logic            itr;
  logic [1:0]      itr_id;
  logic            busy;
  logic [NSRC-1:0] pend;
  logic            err;

  int n_chk  = 0;
  int n_fail = 0;

  // model: phase 0 idle, 1 firing, 2 in service
  logic [NSRC-1:0] m_pend, m_mask, m_prev;
  int m_phase, m_gap, m_svc, m_id;
  bit m_err, m_itr, m_busy;

  itr_sched #(.NSRC(NSRC), .GAP(GAP), .TMOUT(TMOUT)) dut (
    .clk(clk), .rst(rst), .irq_in(irq_in), .mask_wr(mask_wr),
    .mask_data(mask_data), .itr_done(itr_done), .itr(itr),
    .itr_id(itr_id), .busy(busy), .pend(pend), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // advance the model by the rules for one edge, clock the DUT, compare
  task automatic step();
    logic [NSRC-1:0] rise, clr;
    rise = irq_in & ~m_prev;
    clr  = '0;
    if (!rst) begin
      m_pend = '0; m_mask = '1; m_prev = '0;
      m_phase = 0; m_gap = 0; m_svc = 0; m_id = 0; m_err = 0;
    end else begin
      if (m_phase == 0) begin
        if (m_gap > 0) m_gap--;
        else if ((m_pend & m_mask) != '0) begin
          for (int i = NSRC - 1; i >= 0; i--)
            if (m_pend[i] && m_mask[i]) m_id = i;
          clr[m_id] = 1'b1;
          m_phase = 1;
        end
      end else if (m_phase == 1) begin
        m_phase = 2;
        m_svc = 0;
      end else begin
        m_svc++;
        if (itr_done) begin
          m_phase = 0; m_gap = GAP;
        end else if (TMO_ON && m_svc == TMOUT) begin
          m_phase = 0; m_gap = GAP; m_err = 1;
        end
      end
      m_pend = (m_pend & ~clr) | rise;
      m_prev = irq_in;
      if (mask_wr) m_mask = mask_data;
    end
    m_itr  = (m_phase == 1);
    m_busy = (m_phase != 0);
    @(posedge clk);
    #1;
    chk("itr", 32'(itr), 32'(m_itr));
    chk("busy", 32'(busy), 32'(m_busy));
    chk("pend", 32'(pend), 32'(m_pend));
    chk("itr_id", 32'(itr_id), 32'(m_id));
    chk("err", 32'(err), 32'(m_err));
  endtask

  initial begin
    int pulses, t, t_done, t_fire, id2, k;
    m_pend = '0; m_mask = '1; m_prev = '0;
    m_phase = 0; m_gap = 0; m_svc = 0; m_id = 0; m_err = 0;

    // 1: reset
    rst = 1'b0;
    step(); step();
    chk("rst_itr", 32'(itr), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_pend", 32'(pend), 0);
    chk("rst_id", 32'(itr_id), 0);
    chk("rst_err", 32'(err), 0);
    rst = 1'b1;
    step();

    // 2: single source, two-edge latency
    irq_in = 4'b0100;
    step();
    chk("t2_pend", 32'(pend), 32'h4);
    chk("t2_noitr", 32'(itr), 0);
    step();
    chk("t2_itr", 32'(itr), 1);
    chk("t2_id", 32'(itr_id), 2);
    chk("t2_pclr", 32'(pend), 0);
    step();
    chk("t2_onepulse", 32'(itr), 0);
    chk("t2_busy", 32'(busy), 1);
    repeat (2) step();
    itr_done = 1'b1; step(); itr_done = 1'b0;
    chk("t2_idle", 32'(busy), 0);
    irq_in = 4'b0000;
    repeat (GAP + 1) step();

    // 3: simultaneous sources, priority and gap
    irq_in = 4'b1010;
    step(); step();
    chk("t3_id1", 32'(itr_id), 1);
    pulses = 1; t_done = -100; t_fire = -1; id2 = -1;
    for (t = 0; t < 30; t++) begin
      itr_done = (m_phase == 2 && pulses < 2) || (m_phase == 2 && t_fire >= 0);
      if (itr_done && t_done < 0) t_done = t;
      step();
      if (itr) begin
        pulses++;
        if (t_fire < 0) begin t_fire = t; id2 = int'(itr_id); end
      end
    end
    itr_done = 1'b0;
    chk("t3_pulses", 32'(pulses), 2);
    chk("t3_id2", 32'(id2), 3);
    chk("t3_gap", 32'(t_fire - t_done), GAP + 1);

    // 4: masked source latches but does not fire
    irq_in = 4'b0000; step();
    mask_wr = 1'b1; mask_data = 4'b1110; step(); mask_wr = 1'b0;
    irq_in = 4'b0001; step();
    chk("t4_pend", 32'(pend), 32'h1);
    for (int i = 0; i < 6; i++) begin
      step();
      chk("t4_masked", 32'(itr), 0);
    end
    mask_wr = 1'b1; mask_data = 4'b1111; step(); mask_wr = 1'b0;
    step();
    chk("t4_itr", 32'(itr), 1);
    chk("t4_id", 32'(itr_id), 0);
    step();
    itr_done = 1'b1; step(); itr_done = 1'b0;
    irq_in = 4'b0000;
    repeat (GAP + 1) step();

    // 5: edge during service, then re-edge on the clearing edge
    irq_in = 4'b0100; step(); step();
    chk("t5_id2", 32'(itr_id), 2);
    irq_in = 4'b0101; step();
    chk("t5_pend", 32'(pend), 32'h1);
    step(); step();
    chk("t5_wait", 32'(busy), 1);
    irq_in = 4'b0100;
    itr_done = 1'b1; step(); itr_done = 1'b0;
    k = 0;
    while (!(m_phase == 0 && m_gap == 0) && k < 20) begin step(); k++; end
    chk("t5_bound", 32'(k < 20), 1);
    irq_in = 4'b0101; step();
    chk("t5_itr0", 32'(itr), 1);
    chk("t5_id0", 32'(itr_id), 0);
    chk("t5_keep", 32'(pend), 32'h1);

    // drain everything
    for (int i = 0; i < 40; i++) begin
      itr_done = (m_phase == 2);
      step();
    end
    itr_done = 1'b0;
    irq_in = 4'b0000; step();

    // 6: no return from the core
    irq_in = 4'b1000; step(); step();
    chk("t6_fire", 32'(itr), 1);
    repeat (TMOUT) step();
    chk("t6_still", 32'(busy), 1);
    step();
`ifdef ITR_TMO_EN
    chk("t6_tmo_busy", 32'(busy), 0);
    chk("t6_tmo_err", 32'(err), 1);
`else
    chk("t6_hold_busy", 32'(busy), 1);
    chk("t6_hold_err", 32'(err), 0);
`endif
    repeat (GAP + 2) step();

    // reset mid-service
    irq_in = 4'b0000; step();
    itr_done = 1'b1; step(); itr_done = 1'b0;
    repeat (GAP + 1) step();
    irq_in = 4'b0010; step(); step(); step();
    rst = 1'b0; step();
    chk("rs_itr", 32'(itr), 0);
    chk("rs_busy", 32'(busy), 0);
    chk("rs_pend", 32'(pend), 0);
    chk("rs_id", 32'(itr_id), 0);
    chk("rs_err", 32'(err), 0);
    irq_in = 4'b0000; rst = 1'b1; step();

    // random traffic
    for (int n = 0; n < 600; n++) begin
      for (int b = 0; b < NSRC; b++)
        if ($urandom_range(0, 7) == 0) irq_in[b] = ~irq_in[b];
      mask_wr   = ($urandom_range(0, 15) == 0);
      mask_data = NSRC'($urandom);
      itr_done  = ($urandom_range(0, 3) == 0);
      rst       = ($urandom_range(0, 199) != 0);
      step();
    end
    rst = 1'b1; itr_done = 1'b0; mask_wr = 1'b0;
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
